// File: rtl/connect4_board_engine_if.sv
// Command/status bundle between the game controller, the display scanner and
// connect4_board_engine. The master modport drives commands and the slave modport answers them.
interface connect4_board_engine_if;
    logic        clear_board;
    logic        drop_start;
    logic        drop_player;
    logic [2:0]  drop_col;
    logic        drop_done;
    logic        drop_ok;
    logic [2:0]  drop_row;
    logic        check_start;
    logic        check_done;
    logic        g_win;
    logic        o_win;
    logic        busy;
    logic [2:0]  rd_row;
    logic [15:0] rd_data;

    modport master (
        output clear_board, drop_start, drop_player, drop_col, check_start, rd_row,
        input  drop_done, drop_ok, drop_row, check_done, g_win, o_win, busy, rd_data
    );
    modport slave (
        input  clear_board, drop_start, drop_player, drop_col, check_start, rd_row,
        output drop_done, drop_ok, drop_row, check_done, g_win, o_win, busy, rd_data
    );
endinterface

// File: rtl/connect4_board_engine.sv
// Connect-4 8x8 board storage with a drop sequencer and a four-in-a-row scanner.
// Define CHECK_DIAG_EN to include both diagonal directions in the win scan.
module connect4_board_engine (
    input  logic                     clk,
    input  logic                     rst_n,
    connect4_board_engine_if.slave   bus
);
    typedef enum logic [1:0] {D_IDLE, D_SCAN, D_DONE} drop_st_t;
    typedef enum logic [1:0] {C_IDLE, C_SCAN, C_DONE} chk_st_t;

    drop_st_t          drop_st_q;
    chk_st_t           chk_st_q;
    logic [7:0][15:0]  board_q, board_d;
    logic [2:0]        col_q, scan_row_q, drop_row_q, anchor_q;
    logic              player_q, drop_done_q, drop_ok_q;
    logic              check_done_q, g_win_q, o_win_q;
    logic              busy, cell_empty, g_hit, o_hit;
    int                a_i;

    assign busy       = (drop_st_q != D_IDLE) || (chk_st_q != C_IDLE);
    assign cell_empty = (board_q[scan_row_q][{col_q, 1'b0} +: 2] == 2'b00);

    // True when four cells starting at (r,c) and stepping (dr,dc) all hold code.
    function automatic logic line4(input logic [7:0][15:0] b, input int r, input int c,
                                   input int dr, input int dc, input logic [1:0] code);
        logic hit;
        hit = 1'b1;
        for (int k = 0; k < 4; k++)
            if (b[3'(r + k*dr)][4'(2*(c + k*dc)) +: 2] != code) hit = 1'b0;
        return hit;
    endfunction

    always_comb begin
        board_d = board_q;
        if (bus.clear_board && !busy)
            board_d = '0;
        else if (drop_st_q == D_SCAN && cell_empty)
            board_d[scan_row_q][{col_q, 1'b0} +: 2] = player_q ? 2'b10 : 2'b01;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) board_q <= '0;
        else        board_q <= board_d;
    end

    // Windows anchored in the current scan row; each line is seen once over the 8 anchors.
    always_comb begin
        g_hit = 1'b0;
        o_hit = 1'b0;
        a_i   = int'(anchor_q);
        for (int c = 0; c < 8; c++) begin
            if (c <= 4) begin
                g_hit |= line4(board_q, a_i, c, 0, 1, 2'b01);
                o_hit |= line4(board_q, a_i, c, 0, 1, 2'b10);
            end
            if (a_i <= 4) begin
                g_hit |= line4(board_q, a_i, c, 1, 0, 2'b01);
                o_hit |= line4(board_q, a_i, c, 1, 0, 2'b10);
            end
`ifdef CHECK_DIAG_EN
            if (a_i <= 4 && c <= 4) begin
                g_hit |= line4(board_q, a_i, c, 1, 1, 2'b01);
                o_hit |= line4(board_q, a_i, c, 1, 1, 2'b10);
            end
            if (a_i <= 4 && c >= 3) begin
                g_hit |= line4(board_q, a_i, c, 1, -1, 2'b01);
                o_hit |= line4(board_q, a_i, c, 1, -1, 2'b10);
            end
`else
            g_hit |= 1'b0;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_st_q   <= D_IDLE;
            col_q       <= '0;
            player_q    <= 1'b0;
            scan_row_q  <= '0;
            drop_row_q  <= '0;
            drop_ok_q   <= 1'b0;
            drop_done_q <= 1'b0;
        end else begin
            drop_done_q <= 1'b0;
            case (drop_st_q)
                D_IDLE: if (bus.drop_start && chk_st_q == C_IDLE) begin
                    col_q      <= bus.drop_col;
                    player_q   <= bus.drop_player;
                    scan_row_q <= '0;
                    drop_st_q  <= D_SCAN;
                end
                D_SCAN: if (cell_empty) begin
                    drop_row_q <= scan_row_q;
                    drop_ok_q  <= 1'b1;
                    drop_st_q  <= D_DONE;
                end else if (scan_row_q == 3'd7) begin
                    drop_ok_q  <= 1'b0;
                    drop_st_q  <= D_DONE;
                end else begin
                    scan_row_q <= scan_row_q + 3'd1;
                end
                D_DONE: begin
                    drop_done_q <= 1'b1;
                    drop_st_q   <= D_IDLE;
                end
                default: drop_st_q <= D_IDLE;
            endcase
        end
    end

    // A same-cycle drop_start takes precedence, so check only launches without one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chk_st_q     <= C_IDLE;
            anchor_q     <= '0;
            g_win_q      <= 1'b0;
            o_win_q      <= 1'b0;
            check_done_q <= 1'b0;
        end else begin
            check_done_q <= 1'b0;
            case (chk_st_q)
                C_IDLE: if (bus.check_start && !bus.drop_start && drop_st_q == D_IDLE) begin
                    g_win_q  <= 1'b0;
                    o_win_q  <= 1'b0;
                    anchor_q <= '0;
                    chk_st_q <= C_SCAN;
                end
                C_SCAN: begin
                    g_win_q <= g_win_q | g_hit;
                    o_win_q <= o_win_q | o_hit;
                    if (anchor_q == 3'd7) chk_st_q <= C_DONE;
                    else                  anchor_q <= anchor_q + 3'd1;
                end
                C_DONE: begin
                    check_done_q <= 1'b1;
                    chk_st_q     <= C_IDLE;
                end
                default: chk_st_q <= C_IDLE;
            endcase
        end
    end

    assign bus.drop_done  = drop_done_q;
    assign bus.drop_ok    = drop_ok_q;
    assign bus.drop_row   = drop_row_q;
    assign bus.check_done = check_done_q;
    assign bus.g_win      = g_win_q;
    assign bus.o_win      = o_win_q;
    assign bus.busy       = busy;
    assign bus.rd_data    = board_q[bus.rd_row];
endmodule

// File: tb/tb_connect4_board_engine.sv
// Self-checking bench for connect4_board_engine: directed plan items plus random
// games checked against a cell-array board model and a line-search win model.
module tb_connect4_board_engine;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    connect4_board_engine_if ifc();
    connect4_board_engine dut (.clk(clk), .rst_n(rst_n), .bus(ifc.slave));

    int   n_cmp = 0;
    int   n_bad = 0;
    int   mdl [8][8];            // [row][col]: 0 empty, 1 G, 2 O
    logic exp_g = 1'b0;
    logic exp_o = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] mdl_row(input int r);
        logic [15:0] w;
        w = '0;
        for (int c = 0; c < 8; c++) w[2*c +: 2] = 2'(mdl[r][c]);
        return w;
    endfunction

    function automatic logic mdl_win(input int code);
        int dr [4] = '{0, 1, 1, 1};
        int dc [4] = '{1, 0, 1, -1};
        int nd;
        nd = 2;
`ifdef CHECK_DIAG_EN
        nd = 4;
`endif
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                for (int d = 0; d < nd; d++) begin
                    int run;
                    run = 1;
                    for (int k = 0; k < 4; k++) begin
                        int rr, cc;
                        rr = r + k*dr[d];
                        cc = c + k*dc[d];
                        if (rr < 0 || rr > 7 || cc < 0 || cc > 7) run = 0;
                        else if (mdl[rr][cc] != code) run = 0;
                    end
                    if (run == 1) return 1'b1;
                end
        return 1'b0;
    endfunction

    task automatic cmp_board(input string tag);
        for (int r = 0; r < 8; r++) begin
            ifc.rd_row = 3'(r);
            #1;
            chk(tag, ifc.rd_data, mdl_row(r));
        end
    endtask

    task automatic do_drop(input logic p, input int col, input logic with_check);
        int exp_r, lat;
        bit seen_chk;
        seen_chk = 0;
        exp_r = 8;
        for (int r = 7; r >= 0; r--) if (mdl[r][col] == 0) exp_r = r;
        @(negedge clk);
        ifc.drop_player = p;
        ifc.drop_col    = 3'(col);
        ifc.drop_start  = 1'b1;
        ifc.check_start = with_check;
        @(posedge clk); #1;
        ifc.drop_start  = 1'b0;
        ifc.check_start = 1'b0;
        chk("drop_busy", ifc.busy, 1);
        lat = 0;
        for (int n = 1; n <= 20 && lat == 0; n++) begin
            @(posedge clk); #1;
            if (ifc.check_done) seen_chk = 1;
            if (ifc.drop_done) lat = n;
        end
        chk("drop_lat", lat, (exp_r == 8) ? 9 : exp_r + 2);
        chk("drop_ok", ifc.drop_ok, exp_r != 8);
        if (exp_r != 8) begin
            chk("drop_row", ifc.drop_row, exp_r);
            mdl[exp_r][col] = p ? 2 : 1;
        end
        @(posedge clk); #1;
        chk("drop_pulse", ifc.drop_done, 0);
        if (with_check) begin
            repeat (10) begin
                @(posedge clk); #1;
                if (ifc.check_done) seen_chk = 1;
            end
            chk("check_suppressed", seen_chk, 0);
        end
        chk("gwin_hold", ifc.g_win, exp_g);
        chk("owin_hold", ifc.o_win, exp_o);
        cmp_board("drop_board");
    endtask

    task automatic do_check();
        int lat;
        exp_g = mdl_win(1);
        exp_o = mdl_win(2);
        @(negedge clk);
        ifc.check_start = 1'b1;
        @(posedge clk); #1;
        ifc.check_start = 1'b0;
        chk("check_busy", ifc.busy, 1);
        lat = 0;
        for (int n = 1; n <= 20 && lat == 0; n++) begin
            @(posedge clk); #1;
            if (ifc.check_done) lat = n;
        end
        chk("check_lat", lat, 9);
        chk("g_win", ifc.g_win, exp_g);
        chk("o_win", ifc.o_win, exp_o);
        @(posedge clk); #1;
        chk("check_pulse", ifc.check_done, 0);
    endtask

    task automatic do_clear();
        @(negedge clk);
        ifc.clear_board = 1'b1;
        @(posedge clk); #1;
        ifc.clear_board = 1'b0;
        for (int r = 0; r < 8; r++) for (int c = 0; c < 8; c++) mdl[r][c] = 0;
        chk("clear_gwin", ifc.g_win, exp_g);
        chk("clear_owin", ifc.o_win, exp_o);
        cmp_board("clear_board");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        ifc.clear_board = 1'b0;
        ifc.drop_start  = 1'b0;
        ifc.drop_player = 1'b0;
        ifc.drop_col    = '0;
        ifc.check_start = 1'b0;
        ifc.rd_row      = '0;
        for (int r = 0; r < 8; r++) for (int c = 0; c < 8; c++) mdl[r][c] = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", ifc.busy, 0);
        chk("rst_drop_done", ifc.drop_done, 0);
        chk("rst_check_done", ifc.check_done, 0);
        chk("rst_gwin", ifc.g_win, 0);
        chk("rst_owin", ifc.o_win, 0);
        cmp_board("rst_board");
        @(negedge clk);
        rst_n = 1'b1;

        // stacking in one column
        do_drop(1'b0, 3, 1'b0);
        ifc.rd_row = 3'd0; #1;
        chk("row0_g_col3", ifc.rd_data, 16'h0040);
        do_drop(1'b1, 3, 1'b0);
        ifc.rd_row = 3'd1; #1;
        chk("row1_o_col3", ifc.rd_data, 16'h0080);

        // full column
        do_clear();
        for (int i = 0; i < 8; i++) do_drop(i[0], 2, 1'b0);
        do_drop(1'b0, 2, 1'b0);

        // horizontal G win, then cleared board
        do_clear();
        for (int c = 0; c < 4; c++) do_drop(1'b0, c, 1'b0);
        ifc.rd_row = 3'd0; #1;
        chk("row0_g_line", ifc.rd_data, 16'h0055);
        do_check();
        chk("horiz_gwin", ifc.g_win, 1);
        chk("horiz_owin", ifc.o_win, 0);
        do_clear();
        do_check();
        chk("empty_gwin", ifc.g_win, 0);
        chk("empty_owin", ifc.o_win, 0);

        // O up-right diagonal from (0,0)
        do_drop(1'b1, 0, 1'b0);
        do_drop(1'b0, 1, 1'b0); do_drop(1'b1, 1, 1'b0);
        do_drop(1'b0, 2, 1'b0); do_drop(1'b0, 2, 1'b0); do_drop(1'b1, 2, 1'b0);
        do_drop(1'b0, 3, 1'b0); do_drop(1'b0, 3, 1'b0); do_drop(1'b0, 3, 1'b0);
        do_drop(1'b1, 3, 1'b0);
        do_check();
`ifdef CHECK_DIAG_EN
        chk("diag_owin", ifc.o_win, 1);
`else
        chk("diag_owin", ifc.o_win, 0);
`endif
        chk("diag_gwin", ifc.g_win, 0);
        do_drop(1'b0, 5, 1'b1);

        // random games
        repeat (4) begin
            do_clear();
            repeat (24) begin
                do_drop(1'($urandom_range(1, 0)), $urandom_range(7, 0), $urandom_range(9, 0) == 0);
                if ($urandom_range(3, 0) == 0) do_check();
            end
            do_check();
        end

        // reset in the middle of a drop
        @(negedge clk);
        ifc.drop_player = 1'b0;
        ifc.drop_col    = 3'd4;
        ifc.drop_start  = 1'b1;
        @(posedge clk); #1;
        ifc.drop_start = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        for (int r = 0; r < 8; r++) for (int c = 0; c < 8; c++) mdl[r][c] = 0;
        chk("midrst_busy", ifc.busy, 0);
        chk("midrst_gwin", ifc.g_win, 0);
        chk("midrst_owin", ifc.o_win, 0);
        cmp_board("midrst_board");
        @(negedge clk);
        rst_n = 1'b1;
        exp_g = 1'b0;
        exp_o = 1'b0;
        do_drop(1'b1, 4, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
